alert_actuator_ctrl: RTL and testbench

ALERT_ACTUATOR_CTRL -- requirements
Module: alert_actuator_ctrl

---
 rtl/alert_pkg.sv | 21 ++
 rtl/tone_cadence_gen.sv | 66 ++++++
 rtl/alert_actuator_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_alert_actuator_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alert_pkg.sv
// rtl/alert_pkg.sv - shared call-state encoding and default timing constants
//
// Purpose: call FSM state enum and the default parameter values used by
//          alert_actuator_ctrl and tone_cadence_gen (50 MHz clock assumed).
// Ports:   none (package).
package alert_pkg;

  typedef enum logic [2:0] {
    CALL_IDLE     = 3'd0,
    CALL_REQ      = 3'd1,
    CALL_WAIT_ACK = 3'd2,
    CALL_DONE     = 3'd3,
    CALL_FAIL     = 3'd4
  } call_state_e;

  localparam int unsigned DEF_TONE_DIV    = 12500;     // 2 kHz tone half-period
  localparam int unsigned DEF_CADENCE_CYC = 25000000;  // 500 ms on / 500 ms off
  localparam int unsigned DEF_ACK_TIMEOUT = 50000000;  // 1 s per call attempt
  localparam int unsigned DEF_MAX_RETRY   = 3;

endpackage

// File: rtl/tone_cadence_gen.sv
// rtl/tone_cadence_gen.sv - buzzer tone and LED cadence generator
//
// Purpose: while alarm_in is high, alternate on/off phases of CADENCE_CYC
//          cycles; in the on-phase led=1 and buzzer toggles every TONE_DIV
//          cycles, in the off-phase both are 0. A new alarm starts on-phase.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   alarm_in      alarm level from the emergency controller
//   alarm_prev    alarm_in delayed by one cycle (edge detection)
//   buzzer        registered tone drive
//   led           registered cadence LED (high during the on-phase)
module tone_cadence_gen
  import alert_pkg::*;
#(
  parameter int unsigned TONE_DIV    = DEF_TONE_DIV,
  parameter int unsigned CADENCE_CYC = DEF_CADENCE_CYC
) (
  input  logic clk,
  input  logic reset_n,
  input  logic alarm_in,
  input  logic alarm_prev,
  output logic buzzer,
  output logic led
);

  localparam int unsigned TONE_W = $clog2(TONE_DIV + 1);
  localparam int unsigned CAD_W  = $clog2(CADENCE_CYC + 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
  localparam logic [CAD_W-1:0]  CAD_LAST  = CAD_W'(CADENCE_CYC - 1);

  logic [TONE_W-1:0] tone_cnt;
  logic [CAD_W-1:0]  cad_cnt;

  // led doubles as the phase flag: 1 = on-phase, 0 = off-phase.
  // Counters only advance while below their terminal value, so they
  // restart rather than wrap.
  always_ff @(posedge clk) begin
    if (!reset_n || !alarm_in) begin
      buzzer   <= 1'b0;
      led      <= 1'b0;
      tone_cnt <= '0;
      cad_cnt  <= '0;
    end else if (!alarm_prev) begin
      buzzer   <= 1'b1;
      led      <= 1'b1;
      tone_cnt <= '0;
      cad_cnt  <= '0;
    end else if (cad_cnt >= CAD_LAST) begin
      cad_cnt  <= '0;
      tone_cnt <= '0;
      buzzer   <= ~led;
      led      <= ~led;
    end else begin
      cad_cnt <= cad_cnt + CAD_W'(1);
      if (led) begin
        if (tone_cnt >= TONE_LAST) begin
          tone_cnt <= '0;
          buzzer   <= ~buzzer;
        end else begin
          tone_cnt <= tone_cnt + TONE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/alert_actuator_ctrl.sv
// rtl/alert_actuator_ctrl.sv - alert actuators (buzzer, LED, door relay) and help-call FSM
//
// Purpose: drives the alert buzzer/LED cadence and door relay from alarm_in,
//          and runs the help-call handshake (call_req / call_ack) with a
//          per-attempt timeout. All outputs are registered.
// Build option: ALERT_CALL_RETRY_EN - when defined, a timeout re-issues the
//          call up to MAX_RETRY times before failing; otherwise it fails
//          immediately and no retry counter exists.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   alarm_in      alarm level
//   call_help_in  help-request level
//   call_ack      acknowledge from the communication link
//   buzzer, led   tone drive and cadence LED
//   door_relay    alarm_in delayed by one cycle
//   call_req      request to the communication link
//   call_fail     help call failed after all attempts
module alert_actuator_ctrl
  import alert_pkg::*;
#(
  parameter int unsigned TONE_DIV    = DEF_TONE_DIV,
  parameter int unsigned CADENCE_CYC = DEF_CADENCE_CYC,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic clk,
  input  logic reset_n,
  input  logic alarm_in,
  input  logic call_help_in,
  input  logic call_ack,
  output logic buzzer,
  output logic led,
  output logic door_relay,
  output logic call_req,
  output logic call_fail
);

  localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(ACK_TIMEOUT);

  call_state_e     state_q, state_d;
  logic [TO_W-1:0] to_cnt;
  logic            help_prev;
  logic            help_rise, timeout;
  logic            call_req_d, call_fail_d;
  logic            to_clr, to_inc;

  // ---------------- alarm path ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) door_relay <= 1'b0;
    else          door_relay <= alarm_in;
  end

  tone_cadence_gen #(
    .TONE_DIV   (TONE_DIV),
    .CADENCE_CYC(CADENCE_CYC)
  ) u_tone_cadence_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .alarm_in  (alarm_in),
    .alarm_prev(door_relay),
    .buzzer    (buzzer),
    .led       (led)
  );

  // ---------------- call path ----------------
  // help_prev resets to 0 so a level already high at reset release is
  // seen as a rising edge.
  assign help_rise = call_help_in & ~help_prev;
  // to_cnt counts WAIT_ACK cycles from 0; the last allowed cycle is the
  // timeout decision point.
  assign timeout   = (to_cnt >= TO_LAST);

`ifdef ALERT_CALL_RETRY_EN
  localparam int unsigned RT_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRY);

  logic [RT_W-1:0] retry_cnt;
  logic            reissue_q, reissue_d;
  logic            retry_inc, retry_clr;

  // reissue_q marks the one idle cycle spent in REQ before a re-issue,
  // giving the 1-cycle call_req gap between attempts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      retry_cnt <= '0;
      reissue_q <= 1'b0;
    end else begin
      reissue_q <= reissue_d;
      if (retry_clr)
        retry_cnt <= '0;
      else if (retry_inc && retry_cnt < RT_MAX)
        retry_cnt <= retry_cnt + RT_W'(1);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    call_req_d = 1'b0;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
`ifdef ALERT_CALL_RETRY_EN
    reissue_d  = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
`endif
    case (state_q)
      CALL_IDLE: begin
`ifdef ALERT_CALL_RETRY_EN
        retry_clr = 1'b1;
`endif
        if (help_rise) begin
          state_d    = CALL_REQ;
          call_req_d = 1'b1;
        end
      end
      CALL_REQ: begin
        to_clr = 1'b1;
        if (!call_help_in) begin
          state_d = CALL_IDLE;
`ifdef ALERT_CALL_RETRY_EN
        end else if (reissue_q) begin
          call_req_d = 1'b1;
`endif
        end else begin
          state_d    = CALL_WAIT_ACK;
          call_req_d = 1'b1;
        end
      end
      CALL_WAIT_ACK: begin
        to_inc = 1'b1;
        if (!call_help_in) begin
          state_d = CALL_IDLE;
        end else if (call_ack) begin
          state_d = CALL_DONE;
        end else if (timeout) begin
`ifdef ALERT_CALL_RETRY_EN
          if (retry_cnt < RT_MAX) begin
            state_d   = CALL_REQ;
            reissue_d = 1'b1;
            retry_inc = 1'b1;
          end else begin
            state_d = CALL_FAIL;
          end
`else
          state_d = CALL_FAIL;
`endif
        end else begin
          call_req_d = 1'b1;
        end
      end
      CALL_DONE, CALL_FAIL: begin
        if (!call_help_in) state_d = CALL_IDLE;
      end
      default: state_d = CALL_IDLE;
    endcase
    call_fail_d = (state_d == CALL_FAIL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= CALL_IDLE;
      help_prev <= 1'b0;
      to_cnt    <= '0;
      call_req  <= 1'b0;
      call_fail <= 1'b0;
    end else begin
      state_q   <= state_d;
      help_prev <= call_help_in;
      call_req  <= call_req_d;
      call_fail <= call_fail_d;
      if (to_clr)
        to_cnt <= '0;
      else if (to_inc && to_cnt < TO_MAX)
        to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_alert_actuator_ctrl.sv
// tb/tb_alert_actuator_ctrl.sv - directed scoreboard bench for alert_actuator_ctrl
module tb_alert_actuator_ctrl;
  import alert_pkg::*;

  localparam int S_BUZ = 0, S_LED = 1, S_DOOR = 2, S_REQ = 3, S_FAIL = 4, S_ST = 5;
`ifdef ALERT_CALL_RETRY_EN
  localparam int NP = 3;
`else
  localparam int NP = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0, alarm_in = 1'b0, call_help_in = 1'b0, call_ack = 1'b0;
  logic buzzer, led, door_relay, call_req, call_fail;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
    string      tag;
  } exp_t;
  exp_t sb[$];

  alert_actuator_ctrl #(
    .TONE_DIV   (4),
    .CADENCE_CYC(32),
    .ACK_TIMEOUT(20),
    .MAX_RETRY  (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .alarm_in    (alarm_in),
    .call_help_in(call_help_in),
    .call_ack    (call_ack),
    .buzzer      (buzzer),
    .led         (led),
    .door_relay  (door_relay),
    .call_req    (call_req),
    .call_fail   (call_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] observe(int sig);
    case (sig)
      S_BUZ:   return {7'd0, buzzer};
      S_LED:   return {7'd0, led};
      S_DOOR:  return {7'd0, door_relay};
      S_REQ:   return {7'd0, call_req};
      S_FAIL:  return {7'd0, call_fail};
      S_ST:    return 8'(dut.state_q);
      default: return 8'hff;
    endcase
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(int rel, int sig, logic [7:0] val, string tag);
    exp_t e;
    e.cyc = cyc + rel;
    e.sig = sig;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        check(sb[i].tag, observe(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      drain();
    end
  endtask

  initial begin
    int lens[$];
    int gaps[$];
    int run;
    int gap;
    logic prev_req;

    // ---------------- reset ----------------
    tick(3);
    expect_at(0, S_BUZ,  0, "rst_buzzer");
    expect_at(0, S_LED,  0, "rst_led");
    expect_at(0, S_DOOR, 0, "rst_door");
    expect_at(0, S_REQ,  0, "rst_call_req");
    expect_at(0, S_FAIL, 0, "rst_call_fail");
    expect_at(0, S_ST,   8'(CALL_IDLE), "rst_state");
    drain();
    reset_n = 1'b1;
    tick(2);

    // ---------------- alarm cadence ----------------
    alarm_in = 1'b1;
    expect_at(1,  S_BUZ,  1, "al_c1_buzzer");
    expect_at(1,  S_LED,  1, "al_c1_led");
    expect_at(1,  S_DOOR, 1, "al_c1_door");
    expect_at(4,  S_BUZ,  1, "al_c4_buzzer");
    expect_at(5,  S_BUZ,  0, "al_c5_toggle");
    expect_at(9,  S_BUZ,  1, "al_c9_toggle");
    expect_at(32, S_LED,  1, "al_c32_led");
    expect_at(33, S_LED,  0, "al_c33_led_off");
    expect_at(33, S_BUZ,  0, "al_c33_buzzer_off");
    expect_at(40, S_BUZ,  0, "al_c40_buzzer_off");
    expect_at(64, S_LED,  0, "al_c64_led_off");
    expect_at(65, S_LED,  1, "al_c65_led_on");
    expect_at(65, S_BUZ,  1, "al_c65_buzzer_on");
    expect_at(69, S_BUZ,  0, "al_c69_toggle");
    expect_at(70, S_LED,  1, "al_c70_led");
    tick(70);

    alarm_in = 1'b0;
    expect_at(1, S_BUZ,  0, "drop_buzzer");
    expect_at(1, S_LED,  0, "drop_led");
    expect_at(1, S_DOOR, 0, "drop_door");
    tick(3);

    alarm_in = 1'b1;
    expect_at(1,  S_BUZ,  1, "rerise_buzzer");
    expect_at(1,  S_LED,  1, "rerise_led");
    expect_at(1,  S_DOOR, 1, "rerise_door");
    expect_at(4,  S_BUZ,  1, "rerise_c4_buzzer");
    expect_at(5,  S_BUZ,  0, "rerise_c5_toggle");
    expect_at(32, S_LED,  1, "rerise_c32_led");
    expect_at(33, S_LED,  0, "rerise_c33_led_off");
    tick(34);
    alarm_in = 1'b0;
    expect_at(1, S_LED,  0, "drop2_led");
    expect_at(1, S_DOOR, 0, "drop2_door");
    tick(2);

    // ---------------- call with ack ----------------
    call_help_in = 1'b1;
    expect_at(1,  S_REQ,  1, "ack_req_rise");
    expect_at(2,  S_ST,   8'(CALL_WAIT_ACK), "ack_state_wait");
    expect_at(6,  S_REQ,  1, "ack_req_held");
    expect_at(7,  S_REQ,  0, "ack_req_drop");
    expect_at(7,  S_ST,   8'(CALL_DONE), "ack_state_done");
    expect_at(7,  S_FAIL, 0, "ack_no_fail");
    expect_at(10, S_REQ,  0, "done_req_low");
    expect_at(10, S_ST,   8'(CALL_DONE), "done_hold");
    tick(6);
    call_ack = 1'b1;
    tick(1);
    call_ack = 1'b0;
    tick(3);
    call_help_in = 1'b0;
    expect_at(1, S_ST,  8'(CALL_IDLE), "done_to_idle");
    expect_at(1, S_REQ, 0, "done_idle_req");
    tick(2);

    // ---------------- no ack: timeout / retries ----------------
    call_help_in = 1'b1;
    expect_at(21, S_REQ, 1, "to_req_c21");
    expect_at(22, S_REQ, 0, "to_req_c22");
`ifdef ALERT_CALL_RETRY_EN
    expect_at(22, S_FAIL, 0, "to_no_fail_during_retry");
    expect_at(23, S_REQ,  1, "to_reissue_c23");
    expect_at(65, S_REQ,  1, "to_req_c65");
    expect_at(66, S_FAIL, 1, "to_fail_c66");
`else
    expect_at(22, S_FAIL, 1, "to_fail_c22");
`endif
    lens.delete();
    gaps.delete();
    run = 0;
    gap = 0;
    prev_req = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (call_req) begin
        if (!prev_req && lens.size() > 0) gaps.push_back(gap);
        run++;
        gap = 0;
      end else begin
        if (prev_req) lens.push_back(run);
        run = 0;
        gap++;
      end
      prev_req = call_req;
    end
    check("to_pulse_count", 8'(lens.size()), 8'(NP));
    foreach (lens[i]) check($sformatf("to_pulse_len_%0d", i), 8'(lens[i]), 8'd21);
    foreach (gaps[i]) check($sformatf("to_gap_len_%0d", i), 8'(gaps[i]), 8'd1);
    check("to_fail_held", {7'd0, call_fail}, 8'd1);
    call_help_in = 1'b0;
    expect_at(1, S_FAIL, 0, "fail_clear");
    expect_at(1, S_ST,   8'(CALL_IDLE), "fail_to_idle");
    tick(2);

    // ---------------- ack in the timeout cycle ----------------
    call_help_in = 1'b1;
    expect_at(21, S_REQ,  1, "tie_req_c21");
    expect_at(22, S_REQ,  0, "tie_req_drop");
    expect_at(22, S_ST,   8'(CALL_DONE), "tie_state_done");
    expect_at(22, S_FAIL, 0, "tie_no_fail");
    tick(21);
    call_ack = 1'b1;
    tick(1);
    call_ack = 1'b0;
    call_help_in = 1'b0;
    tick(2);

    // ---------------- abort during WAIT_ACK ----------------
    call_help_in = 1'b1;
    tick(4);
    call_help_in = 1'b0;
    expect_at(1, S_REQ,  0, "abort_req");
    expect_at(1, S_FAIL, 0, "abort_fail");
    expect_at(1, S_ST,   8'(CALL_IDLE), "abort_state");
    tick(2);

    // ---------------- reset mid-call ----------------
    alarm_in = 1'b1;
    call_help_in = 1'b1;
    tick(5);
    expect_at(0, S_REQ, 1, "pre_rst_req");
    drain();
    reset_n = 1'b0;
    expect_at(1, S_BUZ,  0, "midrst_buzzer");
    expect_at(1, S_LED,  0, "midrst_led");
    expect_at(1, S_DOOR, 0, "midrst_door");
    expect_at(1, S_REQ,  0, "midrst_req");
    expect_at(1, S_FAIL, 0, "midrst_fail");
    expect_at(1, S_ST,   8'(CALL_IDLE), "midrst_state");
    tick(1);
    reset_n = 1'b1;
    expect_at(1, S_REQ, 1, "release_level_is_edge");
    expect_at(1, S_LED, 1, "release_alarm_on");
    expect_at(1, S_BUZ, 1, "release_buzzer_on");
    tick(2);
    call_help_in = 1'b0;
    alarm_in = 1'b0;
    tick(2);

    check("scoreboard_empty", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
